multicycle_alu: RTL and testbench

Parametrised, registered ALU for the multicycle CPU datapath, replacing the combinational ALU plus separate result register. It executes single-cycle logic/arithmetic/shift operations, plus iterative signed/unsigned multiply and divide, behind a start/busy/done handshake. All results and flags are registered. The control FSM issues `start` and waits for `done` before latching `alu_out` into the register file or memory-address path.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/iter_muldiv.sv | 134 +++++++++++++
 rtl/multicycle_alu.sv | 163 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers
// for the registered multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes,
// with sign fix-up applied combinationally on the final iteration.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rdy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d, div_q, div_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   add_s, trial_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s;
  logic [2*WIDTH-1:0] prod_s;

  assign a_neg_s = is_signed & a[WIDTH-1];
  assign b_neg_s = is_signed & b[WIDTH-1];
  assign a_mag_s = a_neg_s ? -a : a;
  assign b_mag_s = b_neg_s ? -b : b;

  // Multiplier adds the multiplicand when the lsb of the running multiplier is set.
  assign add_s   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
  // Shifted partial remainder never exceeds WIDTH+1 bits, so bit WIDTH is the borrow.
  assign trial_s = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};

  // One iteration of whichever algorithm is running.
  always_comb begin
    step_hi_s = {WIDTH{1'b0}};
    step_lo_s = {WIDTH{1'b0}};
    if (div_q) begin
      if (!trial_s[WIDTH]) begin
        step_hi_s = trial_s[WIDTH-1:0];
        step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = add_s[WIDTH:1];
      step_lo_s = {add_s[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  assign prod_s = neg_lo_q ? -{step_hi_s, step_lo_s} : {step_hi_s, step_lo_s};

  // Final sign correction: whole-product negate, or separate quotient/remainder negate.
  always_comb begin
    lo = {WIDTH{1'b0}};
    hi = {WIDTH{1'b0}};
    if (div_q) begin
      lo = neg_lo_q ? -step_lo_s : step_lo_s;
      hi = neg_hi_q ? -step_hi_s : step_hi_s;
    end else begin
      lo = prod_s[WIDTH-1:0];
      hi = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  assign rdy = active_q && (cnt_q == CNT_ZERO);

  // Operand capture on go, then one iteration per cycle until the counter expires.
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (go) begin
      acc_hi_d = {WIDTH{1'b0}};
      acc_lo_d = a_mag_s;
      opnd_d   = b_mag_s;
      cnt_d    = CNT_LAST;
      active_d = 1'b1;
      div_d    = is_div;
      neg_lo_d = a_neg_s ^ b_neg_s;
      neg_hi_d = is_div & a_neg_s;
    end else if (active_q) begin
      acc_hi_d = step_hi_s;
      acc_lo_d = step_lo_s;
      if (cnt_q == CNT_ZERO) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Datapath and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      active_q <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle ops complete in one clock, mul/div iterate in
// iter_muldiv; results and flags only change in the edge that raises done.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             zero,
  output logic             positive,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d, hi_out_q, hi_out_d;
  logic zero_q, zero_d, positive_q, positive_d, overflow_q, overflow_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] sum_s, diff_s, sc_res_s, md_lo_s, md_hi_s;
  logic [SH_W-1:0]  sh_s;
  logic             sc_ovf_s, sc_def_s, go_s, md_rdy_s, b_zero_s;

  assign sum_s    = alu_a + alu_b;
  assign diff_s   = alu_a - alu_b;
  assign sh_s     = alu_b[SH_W-1:0];
  assign b_zero_s = (alu_b == {WIDTH{1'b0}});

  // Single-cycle result; sc_def_s drops for codes that are not single-cycle ops.
  always_comb begin
    sc_res_s = {WIDTH{1'b0}};
    sc_ovf_s = 1'b0;
    sc_def_s = 1'b1;
    case (alu_op)
      OP_AND:  sc_res_s = alu_a & alu_b;
      OP_OR:   sc_res_s = alu_a | alu_b;
      OP_XOR:  sc_res_s = alu_a ^ alu_b;
      OP_NOR:  sc_res_s = ~(alu_a | alu_b);
      OP_ADD: begin
        sc_res_s = sum_s;
        sc_ovf_s = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_s[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s = diff_s;
        sc_ovf_s = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_s[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SLL:  sc_res_s = alu_a << sh_s;
      OP_SRL:  sc_res_s = alu_a >> sh_s;
      OP_SRA:  sc_res_s = $signed(alu_a) >>> sh_s;
      OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      OP_NOP:  sc_res_s = alu_a;
      default: sc_def_s = 1'b0;
    endcase
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go_s),
    .is_div    (is_div_op(alu_op)),
    .is_signed (is_signed_op(alu_op)),
    .a         (alu_a),
    .b         (alu_b),
    .rdy       (md_rdy_s),
    .lo        (md_lo_s),
    .hi        (md_hi_s)
  );

  // Control FSM and result/flag next-state; DONE accepts a new request like IDLE.
  always_comb begin
    state_d    = state_q;
    alu_out_d  = alu_out_q;
    hi_out_d   = hi_out_q;
    zero_d     = zero_q;
    positive_d = positive_q;
    overflow_d = overflow_q;
    dbz_d      = dbz_q;
    go_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (is_div_op(alu_op) && b_zero_s) begin
            alu_out_d  = {WIDTH{1'b1}};
            hi_out_d   = alu_a;
            zero_d     = 1'b0;
            positive_d = 1'b0;
            overflow_d = 1'b0;
            dbz_d      = 1'b1;
            state_d    = ST_DONE;
          end else if (is_iterative(alu_op)) begin
            go_s    = 1'b1;
            state_d = ST_CALC;
          end else begin
            alu_out_d  = sc_res_s;
            hi_out_d   = {WIDTH{1'b0}};
            zero_d     = sc_def_s && (sc_res_s == {WIDTH{1'b0}});
            positive_d = sc_def_s && !sc_res_s[WIDTH-1] && (sc_res_s != {WIDTH{1'b0}});
            overflow_d = sc_ovf_s;
            dbz_d      = 1'b0;
            state_d    = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (md_rdy_s) begin
          alu_out_d  = md_lo_s;
          hi_out_d   = md_hi_s;
          zero_d     = (md_lo_s == {WIDTH{1'b0}});
          positive_d = !md_lo_s[WIDTH-1] && (md_lo_s != {WIDTH{1'b0}});
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_out_q  <= {WIDTH{1'b0}};
      hi_out_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b1;
      positive_q <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_out_q  <= alu_out_d;
      hi_out_q   <= hi_out_d;
      zero_q     <= zero_d;
      positive_q <= positive_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign done        = (state_q == ST_DONE);
  assign alu_out     = alu_out_q;
  assign hi_out      = hi_out_q;
  assign zero        = zero_q;
  assign positive    = positive_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench: cycle-level reference model plus directed vectors
// with hand-computed expectations.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'h0;
  logic [31:0] alu_a = 32'h0, alu_b = 32'h0;
  logic        busy, done, zero, positive, overflow, div_by_zero;
  logic [31:0] alu_out, hi_out;

  int n_checks = 0;
  int n_fails  = 0;
  bit cmp_en   = 1'b0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .busy(busy), .done(done),
    .alu_out(alu_out), .hi_out(hi_out), .zero(zero), .positive(positive),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] hi;
    logic z, p, o, d;
  } res_t;

  localparam res_t RESET_RES = '{out: 32'h0, hi: 32'h0, z: 1'b1, p: 1'b0, o: 1'b0, d: 1'b0};

  // Architectural result of one request, straight from the arithmetic definitions.
  function automatic res_t alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, t, u;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (op)
      4'h0: r.out = a & b;
      4'h1: r.out = a | b;
      4'h3: r.out = a ^ b;
      4'hC: r.out = ~(a | b);
      4'h2: begin t = sa + sb; r.out = a + b; r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'h6: begin t = sa - sb; r.out = a - b; r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'h4: r.out = a << b[4:0];
      4'h5: r.out = a >> b[4:0];
      4'hD: r.out = $signed(a) >>> b[4:0];
      4'h7: r.out = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: r.out = (a < b) ? 32'd1 : 32'd0;
      4'hF: r.out = a;
      4'h9: begin t = sa * sb; p = t; r.out = p[31:0]; r.hi = p[63:32]; end
      4'hA: begin p = {32'h0, a} * {32'h0, b}; r.out = p[31:0]; r.hi = p[63:32]; end
      4'hB: begin
        if (b == 32'h0) begin r.out = 32'hFFFFFFFF; r.hi = a; r.d = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r.out = 32'h80000000; r.hi = 32'h0; end
        else begin t = sa / sb; u = sa % sb; p = t; r.out = p[31:0]; p = u; r.hi = p[31:0]; end
      end
      4'hE: begin
        if (b == 32'h0) begin r.out = 32'hFFFFFFFF; r.hi = a; r.d = 1'b1; end
        else begin r.out = a / b; r.hi = a % b; end
      end
      default: r.out = 32'h0;
    endcase
    r.z = (r.out == 32'h0);
    r.p = !r.out[31] && (r.out != 32'h0);
    return r;
  endfunction

  function automatic bit model_iter(input logic [3:0] op, input logic [31:0] b);
    return (op == 4'h9 || op == 4'hA || ((op == 4'hB || op == 4'hE) && b != 32'h0));
  endfunction

  // Reference timing: cycles_left counts down the WIDTH busy cycles of an iterative op.
  int   cycles_left;
  res_t m_res, m_pend;
  logic m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_left <= 0;
      m_done      <= 1'b0;
      m_res       <= RESET_RES;
      m_pend      <= RESET_RES;
    end else if (cycles_left > 0) begin
      cycles_left <= cycles_left - 1;
      if (cycles_left == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      if (model_iter(alu_op, alu_b)) begin
        cycles_left <= 32;
        m_pend      <= alu_model(alu_op, alu_a, alu_b);
        m_done      <= 1'b0;
      end else begin
        m_res  <= alu_model(alu_op, alu_a, alu_b);
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_busy", 64'(busy), 64'(cycles_left != 0));
      check("m_done", 64'(done), 64'(m_done));
      check("m_alu_out", 64'(alu_out), 64'(m_res.out));
      check("m_hi_out", 64'(hi_out), 64'(m_res.hi));
      check("m_zero", 64'(zero), 64'(m_res.z));
      check("m_positive", 64'(positive), 64'(m_res.p));
      check("m_overflow", 64'(overflow), 64'(m_res.o));
      check("m_div_by_zero", 64'(div_by_zero), 64'(m_res.d));
    end
  end

  // Issue one request and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input bit now, input bit poke);
    int lat;
    if (!now) @(negedge clk);
    start = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (poke && lat == 5) begin
        start = 1'b1; alu_op = 4'h2; alu_a = 32'h11; alu_b = 32'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", 64'(alu_out), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);

    run_op("add_ovf", 4'h2, 32'h7FFFFFFF, 32'h1, 1, 0, 0);
    check("add_ovf_out", 64'(alu_out), 64'h80000000);
    check("add_ovf_flag", 64'(overflow), 64'd1);
    check("add_ovf_pos", 64'(positive), 64'd0);
    run_op("sub_zero", 4'h6, 32'd5, 32'd5, 1, 0, 0);
    check("sub_zero_flag", 64'(zero), 64'd1);
    run_op("slt", 4'h7, 32'hFFFFFFFF, 32'd1, 1, 0, 0);
    check("slt_out", 64'(alu_out), 64'd1);
    run_op("sltu", 4'h8, 32'hFFFFFFFF, 32'd1, 1, 0, 0);
    check("sltu_out", 64'(alu_out), 64'd0);
    run_op("sra", 4'hD, 32'h80000000, 32'd4, 1, 0, 0);
    check("sra_out", 64'(alu_out), 64'hF8000000);
    run_op("sll", 4'h4, 32'h00000003, 32'd31, 1, 0, 0);
    check("sll_out", 64'(alu_out), 64'h80000000);
    run_op("nor", 4'hC, 32'hF0F0F0F0, 32'h0F0F0000, 1, 0, 0);
    check("nor_out", 64'(alu_out), 64'h00000F0F);
    run_op("nop", 4'hF, 32'h12345678, 32'h0, 1, 0, 0);
    check("nop_pos", 64'(positive), 64'd1);

    run_op("mult", 4'h9, 32'hFFFFFFFD, 32'd7, 33, 0, 1);
    check("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("mult_lo", 64'(alu_out), 64'hFFFFFFEB);
    run_op("multu_max", 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 0);
    check("multu_hi", 64'(hi_out), 64'hFFFFFFFE);
    check("multu_lo", 64'(alu_out), 64'h00000001);
    run_op("div_neg", 4'hB, 32'hFFFFFFF9, 32'd2, 33, 0, 0);
    check("div_neg_q", 64'(alu_out), 64'hFFFFFFFD);
    check("div_neg_r", 64'(hi_out), 64'hFFFFFFFF);
    run_op("divu", 4'hE, 32'd100, 32'd7, 33, 0, 0);
    check("divu_q", 64'(alu_out), 64'd14);
    check("divu_r", 64'(hi_out), 64'd2);
    run_op("div_by0", 4'hB, 32'd9, 32'd0, 1, 0, 0);
    check("div_by0_q", 64'(alu_out), 64'hFFFFFFFF);
    check("div_by0_r", 64'(hi_out), 64'd9);
    check("div_by0_flag", 64'(div_by_zero), 64'd1);
    run_op("div_minneg", 4'hB, 32'h80000000, 32'hFFFFFFFF, 33, 0, 0);
    check("div_minneg_q", 64'(alu_out), 64'h80000000);
    check("div_minneg_r", 64'(hi_out), 64'd0);
    check("div_minneg_dbz", 64'(div_by_zero), 64'd0);

    // Reset in the middle of a MULTU.
    @(negedge clk);
    start = 1'b1; alu_op = 4'hA; alu_a = 32'hFFFFFFFF; alu_b = 32'h12345;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out", 64'(alu_out), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    #2 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("post_abort_no_done", 64'(done), 64'd0);
    end

    run_op("add_after", 4'h2, 32'd3, 32'd4, 1, 0, 0);
    check("add_after_out", 64'(alu_out), 64'd7);
    run_op("add_b2b", 4'h2, 32'd10, 32'd20, 1, 1, 0);
    check("add_b2b_out", 64'(alu_out), 64'd30);
    run_op("sub_b2b", 4'h6, 32'h80000000, 32'd1, 1, 1, 0);
    check("sub_b2b_out", 64'(alu_out), 64'h7FFFFFFF);
    check("sub_b2b_ovf", 64'(overflow), 64'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
